// File: rtl/int_add_rs.sv
// int_add_rs: reservation-station front end for the Tomasulo integer adder.
// Holds add/sub instructions until both operands are resolved from the CDB,
// dispatches one at a time to the rdcla adder, captures the result after a
// fixed latency and offers it to the CDB arbiter.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. valid never depends on ready. Once raised, valid and its payload stay
// put until the transfer edge. ready may be raised or dropped freely.
//
// Debug outputs: dbg_exec_busy is the exec FSM state (0 = IDLE, 1 = BUSY).
// dbg_entry_state packs two bits per entry, with entry i at [2*i +: 2].
// The encoding is FREE = 0, WAIT = 1, READY = 2, EXEC = 3.
module int_add_rs #(
    parameter int NUM_RS  = 4,
    parameter int TAG_W   = 3,
    parameter int ADD_LAT = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic                issue_op,
    input  logic [31:0]         issue_vj,
    input  logic [31:0]         issue_vk,
    input  logic [TAG_W-1:0]    issue_qj,
    input  logic [TAG_W-1:0]    issue_qk,
    output logic [TAG_W-1:0]    issue_tag,
    input  logic                cdb_valid,
    input  logic [TAG_W-1:0]    cdb_tag,
    input  logic [31:0]         cdb_data,
    output logic [31:0]         add_a,
    output logic [31:0]         add_b,
    output logic                add_cin,
    input  logic [31:0]         add_sum,
    input  logic                add_cout,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [TAG_W-1:0]    res_tag,
    output logic [31:0]         res_data,
    output logic                res_cout,
    output logic                dbg_exec_busy,
    output logic [2*NUM_RS-1:0] dbg_entry_state
);

    localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {E_FREE, E_WAIT, E_READY, E_EXEC} entry_state_t;
    typedef enum logic {X_IDLE, X_BUSY} exec_state_t;

    entry_state_t     ent_state [NUM_RS];
    logic             ent_op    [NUM_RS];
    logic [31:0]      ent_vj    [NUM_RS];
    logic [31:0]      ent_vk    [NUM_RS];
    logic [TAG_W-1:0] ent_qj    [NUM_RS];
    logic [TAG_W-1:0] ent_qk    [NUM_RS];

    exec_state_t      x_state;
    logic [CNT_W-1:0] x_cnt;
    logic [TAG_W-1:0] x_tag;

    logic [IDX_W-1:0] alloc_idx;
    logic [IDX_W-1:0] disp_idx;
    logic [IDX_W-1:0] free_idx;
    logic             disp_any;
    logic             issue_fire;
    logic             res_fire;
    logic             dispatch;
    logic             capture;

    logic [NUM_RS-1:0] snoop_j;
    logic [NUM_RS-1:0] snoop_k;
    logic [NUM_RS-1:0] resolved;

    logic             byp_j;
    logic             byp_k;
    logic [31:0]      in_vj;
    logic [31:0]      in_vk;
    logic [TAG_W-1:0] in_qj;
    logic [TAG_W-1:0] in_qk;

    // Lowest FREE entry for allocation; depends on entry state only.
    always_comb begin
        issue_ready = 1'b0;
        alloc_idx   = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (!issue_ready && ent_state[i] == E_FREE) begin
                issue_ready = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
        issue_tag = issue_ready ? (TAG_W'(alloc_idx) + TAG_W'(1)) : '0;
    end

    // Lowest READY entry for dispatch.
    always_comb begin
        disp_any = 1'b0;
        disp_idx = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (!disp_any && ent_state[i] == E_READY) begin
                disp_any = 1'b1;
                disp_idx = IDX_W'(i);
            end
        end
    end

    // CDB snoop match per waiting entry, and whether it becomes fully resolved.
    always_comb begin
        snoop_j  = '0;
        snoop_k  = '0;
        resolved = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            snoop_j[i]  = cdb_valid && (ent_state[i] == E_WAIT) &&
                          (ent_qj[i] != '0) && (ent_qj[i] == cdb_tag);
            snoop_k[i]  = cdb_valid && (ent_state[i] == E_WAIT) &&
                          (ent_qk[i] != '0) && (ent_qk[i] == cdb_tag);
            resolved[i] = (snoop_j[i] || ent_qj[i] == '0) &&
                          (snoop_k[i] || ent_qk[i] == '0);
        end
    end

    // Issue bypass: a tag broadcast in the accepting cycle resolves it at once.
    always_comb begin
        byp_j = cdb_valid && (issue_qj != '0) && (cdb_tag == issue_qj);
        byp_k = cdb_valid && (issue_qk != '0) && (cdb_tag == issue_qk);
        in_vj = byp_j ? cdb_data : issue_vj;
        in_vk = byp_k ? cdb_data : issue_vk;
        in_qj = byp_j ? '0 : issue_qj;
        in_qk = byp_k ? '0 : issue_qk;
    end

    // Packed view of entry states for debug.
    always_comb begin
        dbg_entry_state = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            dbg_entry_state[2*i +: 2] = ent_state[i];
        end
    end

    assign issue_fire    = issue_valid && issue_ready;
    assign res_fire      = res_valid && res_ready;
    assign dispatch      = (x_state == X_IDLE) && disp_any && (!res_valid || res_ready);
    assign capture       = (x_state == X_BUSY) && (x_cnt == CNT_W'(ADD_LAT - 1));
    assign free_idx      = IDX_W'(res_tag - TAG_W'(1));
    assign dbg_exec_busy = (x_state == X_BUSY);

    // Entry lifecycle: allocate, snoop, dispatch, and free on result handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_RS; i++) begin
                ent_state[i] <= E_FREE;
                ent_op[i]    <= 1'b0;
                ent_vj[i]    <= '0;
                ent_vk[i]    <= '0;
                ent_qj[i]    <= '0;
                ent_qk[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RS; i++) begin
                case (ent_state[i])
                    E_FREE: begin
                        if (issue_fire && alloc_idx == IDX_W'(i)) begin
                            ent_op[i]    <= issue_op;
                            ent_vj[i]    <= in_vj;
                            ent_vk[i]    <= in_vk;
                            ent_qj[i]    <= in_qj;
                            ent_qk[i]    <= in_qk;
                            ent_state[i] <= (in_qj == '0 && in_qk == '0) ? E_READY : E_WAIT;
                        end
                    end
                    E_WAIT: begin
                        if (snoop_j[i]) begin
                            ent_vj[i] <= cdb_data;
                            ent_qj[i] <= '0;
                        end
                        if (snoop_k[i]) begin
                            ent_vk[i] <= cdb_data;
                            ent_qk[i] <= '0;
                        end
                        if (resolved[i]) begin
                            ent_state[i] <= E_READY;
                        end
                    end
                    E_READY: begin
                        if (dispatch && disp_idx == IDX_W'(i)) begin
                            ent_state[i] <= E_EXEC;
                        end
                    end
                    E_EXEC: begin
                        if (res_fire && free_idx == IDX_W'(i)) begin
                            ent_state[i] <= E_FREE;
                        end
                    end
                    default: ent_state[i] <= E_FREE;
                endcase
            end
        end
    end

    // Exec FSM: drive and hold adder operands, count latency, own the result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_state   <= X_IDLE;
            x_cnt     <= '0;
            x_tag     <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            res_valid <= 1'b0;
            res_tag   <= '0;
            res_data  <= '0;
            res_cout  <= 1'b0;
        end else begin
            if (dispatch) begin
                add_a   <= ent_vj[disp_idx];
                add_b   <= ent_vk[disp_idx];
                add_cin <= ent_op[disp_idx];
                x_tag   <= TAG_W'(disp_idx) + TAG_W'(1);
                x_cnt   <= '0;
                x_state <= X_BUSY;
            end else if (x_state == X_BUSY) begin
                if (capture) begin
                    x_state <= X_IDLE;
                end else begin
                    x_cnt <= x_cnt + CNT_W'(1);
                end
            end

            if (capture) begin
                res_valid <= 1'b1;
                res_tag   <= x_tag;
                res_data  <= add_sum;
                res_cout  <= add_cout;
            end else if (res_fire) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_int_add_rs.sv
// Testbench for int_add_rs: directed steps with a result scoreboard and a
// behavioural model of the rdcla adder driven from the registered operands.
module tb_int_add_rs;

  localparam int NUM_RS  = 4;
  localparam int TAG_W   = 3;
  localparam int ADD_LAT = 7;

  logic                clk;
  logic                rst;
  logic                issue_valid;
  logic                issue_ready;
  logic                issue_op;
  logic [31:0]         issue_vj;
  logic [31:0]         issue_vk;
  logic [TAG_W-1:0]    issue_qj;
  logic [TAG_W-1:0]    issue_qk;
  logic [TAG_W-1:0]    issue_tag;
  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_tag;
  logic [31:0]         cdb_data;
  logic [31:0]         add_a;
  logic [31:0]         add_b;
  logic                add_cin;
  logic [31:0]         add_sum;
  logic                add_cout;
  logic                res_valid;
  logic                res_ready;
  logic [TAG_W-1:0]    res_tag;
  logic [31:0]         res_data;
  logic                res_cout;
  logic                dbg_exec_busy;
  logic [2*NUM_RS-1:0] dbg_entry_state;

  int errors;
  int checks;

  // expected result: {tag, cout, data}
  logic [TAG_W+32:0] exp_q[$];

  int_add_rs #(.NUM_RS(NUM_RS), .TAG_W(TAG_W), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_tag(res_tag), .res_data(res_data), .res_cout(res_cout),
    .dbg_exec_busy(dbg_exec_busy), .dbg_entry_state(dbg_entry_state)
  );

  // rdcla model: subtract is a + ~b + 1 via carry-in
  logic [32:0] add_full;
  assign add_full = {1'b0, add_a} + {1'b0, add_b ^ {32{add_cin}}} + {32'd0, add_cin};
  assign add_sum  = add_full[31:0];
  assign add_cout = add_full[32];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [TAG_W+32:0] exp_res(input logic [TAG_W-1:0] tag, input logic op,
                                               input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    if (op) s = {1'b0, a} - {1'b0, b} + 33'h1_0000_0000;
    else    s = {1'b0, a} + {1'b0, b};
    return {tag, s[32], s[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge; a handshake seen before the edge is scored after it
  task automatic tick();
    logic              hs;
    logic [TAG_W+32:0] obs;
    hs  = res_valid && res_ready;
    obs = {res_tag, res_cout, res_data};
    @(posedge clk);
    if (hs) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: got result %0h expected no result", obs);
      end
      if (exp_q.size() != 0) chk("sb_result", 64'(obs), 64'(exp_q.pop_front()));
    end
    #1;
  endtask

  // driver tasks
  task automatic offer(input logic op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [TAG_W-1:0] qj, input logic [TAG_W-1:0] qk);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_vj    = vj;
    issue_vk    = vk;
    issue_qj    = qj;
    issue_qk    = qk;
  endtask

  task automatic cdb(input logic v, input logic [TAG_W-1:0] tag, input logic [31:0] data);
    cdb_valid = v;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  task automatic wait_res(input string tag, input int budget);
    int n;
    n = 0;
    while (!res_valid && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (res_valid === 1'b1) else begin
      errors++;
      $error("FAIL %s: res_valid got %b expected 1 within %0d cycles", tag, res_valid, budget);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    issue_valid = 1'b0; issue_op = 1'b0; issue_vj = '0; issue_vk = '0;
    issue_qj = '0; issue_qk = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("rst_issue_tag",   64'(issue_tag),   64'd1);
    chk("rst_res_valid",   64'(res_valid),   64'd0);
    chk("rst_res_payload", 64'({res_tag, res_cout, res_data}), 64'd0);
    chk("rst_add_a",       64'(add_a),       64'd0);
    chk("rst_add_b_cin",   64'({add_b, add_cin}), 64'd0);
    chk("rst_entries",     64'(dbg_entry_state), 64'd0);
    rst = 1'b0;
    tick();

    // add 5+7: accept edge 0, dispatch edge 1, result after edge 8
    res_ready = 1'b1;
    chk("t1_issue_tag", 64'(issue_tag), 64'd1);
    offer(1'b0, 32'd5, 32'd7, 3'd0, 3'd0);
    exp_q.push_back(exp_res(3'd1, 1'b0, 32'd5, 32'd7));
    tick();
    issue_valid = 1'b0;
    chk("t1_ready_state", 64'(dbg_entry_state), 64'h2);
    tick();
    chk("t1_add_a",   64'(add_a),   64'd5);
    chk("t1_add_b",   64'(add_b),   64'd7);
    chk("t1_add_cin", 64'(add_cin), 64'd0);
    repeat (6) tick();
    chk("t1_res_valid_e7", 64'(res_valid), 64'd0);
    tick();
    chk("t1_res_valid_e8", 64'(res_valid), 64'd1);
    chk("t1_res_tag",  64'(res_tag),  64'd1);
    chk("t1_res_data", 64'(res_data), 64'd12);
    tick();
    chk("t1_res_valid_after_hs", 64'(res_valid), 64'd0);
    chk("t1_freed_tag", 64'(issue_tag), 64'd1);

    // sub 3-5: carry-in held through capture
    offer(1'b1, 32'd3, 32'd5, 3'd0, 3'd0);
    exp_q.push_back(exp_res(3'd1, 1'b1, 32'd3, 32'd5));
    tick();
    issue_valid = 1'b0;
    tick();
    chk("t2_add_cin", 64'(add_cin), 64'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t2_cin_hold", 64'(add_cin), 64'd1);
      chk("t2_a_hold",   64'(add_a),   64'd3);
    end
    tick();
    chk("t2_res_valid", 64'(res_valid), 64'd1);
    chk("t2_res_data",  64'(res_data),  64'hFFFF_FFFE);
    chk("t2_res_cout",  64'(res_cout),  64'd0);
    tick();

    // WAIT entry resolved by CDB snoop
    offer(1'b0, 32'd0, 32'd1, 3'd3, 3'd0);
    exp_q.push_back(exp_res(3'd1, 1'b0, 32'h10, 32'd1));
    tick();
    issue_valid = 1'b0;
    chk("t3_wait_state", 64'(dbg_entry_state), 64'h1);
    tick();
    chk("t3_no_early_dispatch", 64'(dbg_exec_busy), 64'd0);
    cdb(1'b1, 3'd3, 32'h10);
    tick();
    cdb(1'b0, 3'd0, 32'd0);
    chk("t3_ready_after_snoop", 64'(dbg_entry_state), 64'h2);
    chk("t3_idle_at_snoop", 64'(dbg_exec_busy), 64'd0);
    tick();
    chk("t3_busy",  64'(dbg_exec_busy), 64'd1);
    chk("t3_add_a", 64'(add_a), 64'h10);
    chk("t3_add_b", 64'(add_b), 64'd1);
    wait_res("t3_result", 10);
    tick();

    // issue bypass from the CDB in the accepting cycle
    offer(1'b0, 32'd0, 32'd5, 3'd2, 3'd0);
    cdb(1'b1, 3'd2, 32'h40);
    exp_q.push_back(exp_res(3'd1, 1'b0, 32'h40, 32'd5));
    tick();
    issue_valid = 1'b0;
    cdb(1'b0, 3'd0, 32'd0);
    chk("t4_ready_state", 64'(dbg_entry_state), 64'h2);
    tick();
    chk("t4_add_a", 64'(add_a), 64'h40);
    chk("t4_add_b", 64'(add_b), 64'd5);
    wait_res("t4_result", 10);
    tick();

    // fill all entries, backpressure, then drain in index order
    res_ready = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      chk("t5_alloc_tag", 64'(issue_tag), 64'(i + 1));
      offer(i == 1, 32'hDEAD, 32'(100 + i), 3'd5, (i == 3) ? 3'd5 : 3'd0);
      if (i == 3) exp_q.push_back(exp_res(3'(i + 1), 1'b0, 32'h1000, 32'h1000));
      else        exp_q.push_back(exp_res(3'(i + 1), i == 1, 32'h1000, 32'(100 + i)));
      tick();
    end
    offer(1'b0, 32'd1, 32'd1, 3'd0, 3'd0);
    chk("t5_full_ready", 64'(issue_ready), 64'd0);
    tick();
    tick();
    issue_valid = 1'b0;
    chk("t5_all_wait", 64'(dbg_entry_state), 64'h55);
    cdb(1'b1, 3'd5, 32'h1000);
    tick();
    cdb(1'b0, 3'd0, 32'd0);
    chk("t5_all_ready", 64'(dbg_entry_state), 64'hAA);
    tick();
    chk("t5_first_a", 64'(add_a), 64'h1000);
    chk("t5_first_b", 64'(add_b), 64'd100);
    wait_res("t5_first_result", 10);
    repeat (10) tick();
    chk("t5_held_valid", 64'(res_valid), 64'd1);
    chk("t5_held_tag",   64'(res_tag),   64'd1);
    chk("t5_no_second_dispatch", 64'({dbg_exec_busy, add_b}), 64'd100);
    res_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        tick();
        n++;
      end
    end
    chk("t5_drained", 64'(exp_q.size()), 64'd0);
    chk("t5_freed_ready", 64'(issue_ready), 64'd1);
    chk("t5_freed_tag",   64'(issue_tag),   64'd1);
    chk("t5_freed_state", 64'(dbg_entry_state), 64'd0);
    repeat (3) tick();
    chk("t5_no_extra_result", 64'(res_valid), 64'd0);

    // asynchronous reset mid-operation discards everything
    offer(1'b0, 32'd9, 32'd9, 3'd0, 3'd0);
    tick();
    issue_valid = 1'b0;
    tick();
    chk("t6_busy", 64'(dbg_exec_busy), 64'd1);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_res_valid",   64'(res_valid),   64'd0);
    chk("t6_rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("t6_rst_issue_tag",   64'(issue_tag),   64'd1);
    chk("t6_rst_entries",     64'(dbg_entry_state), 64'd0);
    chk("t6_rst_busy",        64'(dbg_exec_busy), 64'd0);
    chk("t6_rst_add_a",       64'(add_a), 64'd0);
    tick();
    rst = 1'b0;
    repeat (12) tick();
    chk("t6_no_stale_result", 64'(res_valid), 64'd0);

    // normal operation after reset
    offer(1'b1, 32'd10, 32'd4, 3'd0, 3'd0);
    exp_q.push_back(exp_res(3'd1, 1'b1, 32'd10, 32'd4));
    tick();
    issue_valid = 1'b0;
    wait_res("t7_result", 12);
    tick();
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
